// File: rtl/sdf_bf_stage_256.sv
// Radix-2 single-path delay-feedback butterfly stage (256-point span).
// Follows the twiddle ROM phase code: fill, butterfly sums, twiddled differences.
module sdf_bf_stage_256 #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 128,
  parameter int FRAC   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int MW = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MAX_C = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_C = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [MW:0]       RND_C = {{(MW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic [PW-1:0]     ONE_C = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_BF   = 2'd1,
    PH_TW   = 2'd2,
    PH_ILL  = 2'd3
  } phase_e;

  // Saturate a one-bit-grown sum back to DATA_W.
  function automatic logic [DATA_W-1:0] sat_narrow(input logic [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1]) begin
      return v[DATA_W] ? MIN_C : MAX_C;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  function automatic logic [DATA_W-1:0] sat_wide(input logic [MW:0] v);
    if ((&v[MW:DATA_W-1]) || ~(|v[MW:DATA_W-1])) begin
      return v[DATA_W-1:0];
    end else begin
      return v[MW] ? MIN_C : MAX_C;
    end
  endfunction

  logic [MW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;

  phase_e            phase_s;
  logic              advance_s;
  logic              we_s;
  logic [MW-1:0]     wdata_s;
  logic [DATA_W-1:0] b_r_s, b_i_s, a_r_s, a_i_s;
  logic [DATA_W-1:0] sum_r_s, sum_i_s, dif_r_s, dif_i_s;
  logic [MW-1:0]     p_rr_s, p_ii_s, p_ri_s, p_ir_s;
  logic [MW:0]       tw_re_s, tw_im_s, sh_re_s, sh_im_s;

  assign phase_s   = phase_e'(state);
  assign advance_s = in_valid || (phase_s == PH_BF) || (phase_s == PH_TW);
  assign a_r_s     = mem_q[ptr_q][MW-1:DATA_W];
  assign a_i_s     = mem_q[ptr_q][DATA_W-1:0];

  // Input forced to zero while the ROM phase counter free-runs without data.
  always_comb begin
    b_r_s = {DATA_W{1'b0}};
    b_i_s = {DATA_W{1'b0}};
    if (in_valid) begin
      b_r_s = din_r;
      b_i_s = din_i;
    end else begin
      b_r_s = {DATA_W{1'b0}};
      b_i_s = {DATA_W{1'b0}};
    end
  end

  assign sum_r_s = sat_narrow({a_r_s[DATA_W-1], a_r_s} + {b_r_s[DATA_W-1], b_r_s});
  assign sum_i_s = sat_narrow({a_i_s[DATA_W-1], a_i_s} + {b_i_s[DATA_W-1], b_i_s});
  assign dif_r_s = sat_narrow({a_r_s[DATA_W-1], a_r_s} - {b_r_s[DATA_W-1], b_r_s});
  assign dif_i_s = sat_narrow({a_i_s[DATA_W-1], a_i_s} - {b_i_s[DATA_W-1], b_i_s});

  // Full-width signed products of the buffered difference and the twiddle.
  assign p_rr_s = $signed({{DATA_W{a_r_s[DATA_W-1]}}, a_r_s}) * $signed({{DATA_W{w_r[DATA_W-1]}}, w_r});
  assign p_ii_s = $signed({{DATA_W{a_i_s[DATA_W-1]}}, a_i_s}) * $signed({{DATA_W{w_i[DATA_W-1]}}, w_i});
  assign p_ri_s = $signed({{DATA_W{a_r_s[DATA_W-1]}}, a_r_s}) * $signed({{DATA_W{w_i[DATA_W-1]}}, w_i});
  assign p_ir_s = $signed({{DATA_W{a_i_s[DATA_W-1]}}, a_i_s}) * $signed({{DATA_W{w_r[DATA_W-1]}}, w_r});

  assign tw_re_s = {p_rr_s[MW-1], p_rr_s} - {p_ii_s[MW-1], p_ii_s} + RND_C;
  assign tw_im_s = {p_ri_s[MW-1], p_ri_s} + {p_ir_s[MW-1], p_ir_s} + RND_C;
  assign sh_re_s = $signed(tw_re_s) >>> FRAC;
  assign sh_im_s = $signed(tw_im_s) >>> FRAC;

  // Next-state selection per ROM phase.
  always_comb begin
    ptr_d       = ptr_q;
    we_s        = 1'b0;
    wdata_s     = {b_r_s, b_i_s};
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    case (phase_s)
      PH_BF: begin
        wdata_s     = {dif_r_s, dif_i_s};
        out_valid_d = 1'b1;
        dout_r_d    = sum_r_s;
        dout_i_d    = sum_i_s;
      end
      PH_TW: begin
        out_valid_d = 1'b1;
        dout_r_d    = sat_wide(sh_re_s);
        dout_i_d    = sat_wide(sh_im_s);
      end
      PH_FILL, PH_ILL: begin
        out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
    if (advance_s) begin
      we_s  = 1'b1;
      ptr_d = ptr_q + ONE_C;
    end else begin
      we_s  = 1'b0;
      ptr_d = ptr_q;
    end
  end

  // Delay line storage; contents deliberately unreset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[ptr_q] <= wdata_s;
    end
  end

  // Pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= {PW{1'b0}};
      out_valid_q <= 1'b0;
      dout_r_q    <= {DATA_W{1'b0}};
      dout_i_q    <= {DATA_W{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
endmodule

// File: tb/tb_sdf_bf_stage_256.sv
// Bench for sdf_bf_stage_256: frame-level reference model feeding a scoreboard,
// plus a table of hand-derived output values per frame type.
module tb_sdf_bf_stage_256;
  localparam int W = 24;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic [1:0]          state = 2'd0;
  logic                out_valid;
  logic signed [W-1:0] dout_r, dout_i;

  sdf_bf_stage_256 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .state(state), .w_r(w_r), .w_i(w_i), .out_valid(out_valid),
    .dout_r(dout_r), .dout_i(dout_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint              due;
    int                  idx;
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;
  } sb_t;

  typedef struct {
    int kind;
    int idx;
    int er;
    int ei;
  } vec_t;

  sb_t                 sb_q[$];
  sb_t                 mon_e;
  vec_t                vecs[16];
  longint              cyc = 0;
  int                  checks = 0;
  int                  errors = 0;
  logic signed [W-1:0] fr_r[4][256], fr_i[4][256];
  logic signed [W-1:0] tw_r[128], tw_i[128];
  logic signed [W-1:0] exp_r[256], exp_i[256];
  logic signed [W-1:0] cap_r[256], cap_i[256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [W-1:0] sat(input longint v);
    if (v > 64'sd8388607) return 24'sh7FFFFF;
    else if (v < -64'sd8388608) return 24'sh800000;
    else return W'(v);
  endfunction

  function automatic logic signed [W-1:0] rnd24();
    logic [31:0] t;
    t = $urandom();
    return t[W-1:0];
  endfunction

  function automatic int rnd_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // Reference radix-2 DIF stage: sums, then saturated differences times twiddle.
  task automatic compute(input int f);
    longint ar, ai, br, bi, dr, di, pr, pi;
    for (int k = 0; k < 128; k++) begin
      ar = fr_r[f][k];      ai = fr_i[f][k];
      br = fr_r[f][k+128];  bi = fr_i[f][k+128];
      exp_r[k] = sat(ar + br);
      exp_i[k] = sat(ai + bi);
      dr = sat(ar - br);
      di = sat(ai - bi);
      pr = (dr * longint'(tw_r[k]) - di * longint'(tw_i[k]) + 64'sd128) >>> 8;
      pi = (dr * longint'(tw_i[k]) + di * longint'(tw_r[k]) + 64'sd128) >>> 8;
      exp_r[128+k] = sat(pr);
      exp_i[128+k] = sat(pi);
    end
  endtask

  task automatic make_frame(input int f, input int kind);
    for (int k = 0; k < 256; k++) begin
      case (kind)
        0: begin fr_r[f][k] = (k == 0) ? 24'sd256 : 24'sd0; fr_i[f][k] = 24'sd0; end
        1: begin fr_r[f][k] = 24'sd100; fr_i[f][k] = -24'sd50; end
        2: begin fr_r[f][k] = (k < 128) ? 24'sd256 : 24'sd0; fr_i[f][k] = 24'sd0; end
        3: begin
          fr_r[f][k] = (k == 0 || k == 128) ? 24'sh7FFFFF : 24'sd0;
          fr_i[f][k] = (k == 0 || k == 128) ? 24'sh800000 : 24'sd0;
        end
        default: begin fr_r[f][k] = rnd24(); fr_i[f][k] = rnd24(); end
      endcase
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic v, input logic signed [W-1:0] dr,
                       input logic signed [W-1:0] di, input logic signed [W-1:0] wr,
                       input logic signed [W-1:0] wi);
    @(posedge clk);
    #1;
    state = st; in_valid = v; din_r = dr; din_i = di; w_r = wr; w_i = wi;
  endtask

  task automatic push(input int idx);
    sb_t e;
    e.due = cyc + 1; e.idx = idx; e.r = exp_r[idx]; e.i = exp_i[idx];
    sb_q.push_back(e);
  endtask

  task automatic clear_cap();
    for (int k = 0; k < 256; k++) begin cap_r[k] = 24'sh555555; cap_i[k] = 24'sh555555; end
  endtask

  // Fill phase for frame 0; optional idle gaps and use of the illegal phase code.
  task automatic run_fill(input int gaps, input logic use3);
    for (int k = 0; k < 128; k++) begin
      if (gaps != 0 && (k % 5) == 2) drive(use3 ? 2'd3 : 2'd0, 1'b0, rnd24(), rnd24(), rnd24(), rnd24());
      drive(use3 ? 2'd3 : 2'd0, 1'b1, fr_r[0][k], fr_i[0][k], rnd24(), rnd24());
    end
  endtask

  // Butterfly then twiddle phases for each frame, back to back, then a zero flush.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      compute(f);
      for (int k = 0; k < 128; k++) begin
        drive(2'd1, 1'b1, fr_r[f][128+k], fr_i[f][128+k], rnd24(), rnd24());
        push(k);
      end
      for (int k = 0; k < 128; k++) begin
        if (f < n - 1) drive(2'd2, 1'b1, fr_r[f+1][k], fr_i[f+1][k], tw_r[k], tw_i[k]);
        else drive(2'd2, 1'b0, rnd24(), rnd24(), tw_r[k], tw_i[k]);
        push(128 + k);
      end
    end
    for (int k = 0; k < 4; k++) drive(2'd0, 1'b0, rnd24(), rnd24(), rnd24(), rnd24());
  endtask

  task automatic check_table(input int kind);
    logic signed [W-1:0] er, ei;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].kind == kind) begin
        er = W'(vecs[i].er);
        ei = W'(vecs[i].ei);
        checks++;
        if (cap_r[vecs[i].idx] !== er || cap_i[vecs[i].idx] !== ei) begin
          errors++;
          $display("FAIL table kind%0d idx%0d: got (%0d,%0d) want (%0d,%0d)", kind, vecs[i].idx,
                   cap_r[vecs[i].idx], cap_i[vecs[i].idx], er, ei);
        end
      end
    end
  endtask

  // Output monitor: reset values, exact-cycle scoreboard match, or silence.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (out_valid !== 1'b0 || dout_r !== 24'sd0 || dout_i !== 24'sd0) begin
        errors++;
        $display("FAIL reset_out: got v=%b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
      end
    end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      cap_r[mon_e.idx] = dout_r;
      cap_i[mon_e.idx] = dout_i;
      checks++;
      if (out_valid !== 1'b1 || dout_r !== mon_e.r || dout_i !== mon_e.i) begin
        errors++;
        $display("FAIL out[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", mon_e.idx, out_valid,
                 dout_r, dout_i, mon_e.r, mon_e.i);
      end
    end else begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid: got out_valid=%b want 0", out_valid);
      end
    end
  end

  initial begin
    real ang;
    vecs[0]  = '{0, 0,   256, 0};       vecs[1]  = '{0, 1,   0, 0};
    vecs[2]  = '{0, 128, 256, 0};       vecs[3]  = '{0, 200, 0, 0};
    vecs[4]  = '{1, 0,   200, -100};    vecs[5]  = '{1, 127, 200, -100};
    vecs[6]  = '{1, 128, 0, 0};         vecs[7]  = '{1, 255, 0, 0};
    vecs[8]  = '{2, 160, 181, -181};    vecs[9]  = '{2, 192, 0, -256};
    vecs[10] = '{2, 255, -256, -6};     vecs[11] = '{2, 128, 256, 0};
    vecs[12] = '{3, 0,   8388607, -8388608};
    vecs[13] = '{3, 128, 0, 0};         vecs[14] = '{3, 1, 0, 0};
    vecs[15] = '{9, 0, 0, 0};
    for (int k = 0; k < 128; k++) begin
      ang = 2.0 * 3.141592653589793 * k / 256.0;
      tw_r[k] = W'(rnd_real(256.0 * $cos(ang)));
      tw_i[k] = W'(rnd_real(-256.0 * $sin(ang)));
    end

    for (int k = 0; k < 8; k++) drive(2'($urandom_range(3)), 1'($urandom_range(1)), rnd24(), rnd24(), rnd24(), rnd24());
    drive(2'd0, 1'b0, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
    rst_n = 1'b1;

    // Impulse with idle gaps in the fill.
    clear_cap(); make_frame(0, 0); run_fill(1, 1'b0); run_frames(1); check_table(0);
    // DC with the illegal phase code during fill.
    clear_cap(); make_frame(0, 1); run_fill(0, 1'b1); run_frames(1); check_table(1);
    clear_cap(); make_frame(0, 2); run_fill(0, 1'b0); run_frames(1); check_table(2);
    clear_cap(); make_frame(0, 3); run_fill(0, 1'b0); run_frames(1); check_table(3);

    // Continuous stream: random, twiddle, DC frames with seamless 2->1 handoff.
    clear_cap(); make_frame(0, 4); make_frame(1, 2); make_frame(2, 1);
    run_fill(0, 1'b0); run_frames(3); check_table(1);

    // Reset at sample 200 of a random frame, then a clean DC frame.
    make_frame(0, 4); run_fill(0, 1'b0); compute(0);
    for (int k = 0; k < 72; k++) begin
      drive(2'd1, 1'b1, fr_r[0][128+k], fr_i[0][128+k], rnd24(), rnd24());
      push(k);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; sb_q.delete();
    state = 2'd0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) drive(2'd1, 1'b1, rnd24(), rnd24(), rnd24(), rnd24());
    drive(2'd0, 1'b0, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
    rst_n = 1'b1;
    clear_cap(); make_frame(0, 1); run_fill(0, 1'b0); run_frames(1); check_table(1);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending outputs want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdf_bf_stage_256.md
# sdf_bf_stage_256

Radix-2 single-path delay-feedback (SDF) butterfly stage for the 256-point span of the 1024-point FFT pipeline. It is the consumer of the 128-entry twiddle ROM. The stage follows the ROM's `state` phase code, buffers the first 128 samples, and emits 128 butterfly sums. It then emits 128 differences multiplied by the ROM twiddle `w_r`/`w_i`. Output streams straight into the next (128-point) stage.

## Interface
- `DATA_W`, 24 — signed sample width, real and imaginary.
- `DEPTH`, 128 — delay-line length (half span).
- `FRAC`, 8 — twiddle fraction bits (Q8: 256 = 1.0).

- `clk`  in  1  — clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — `din_r`/`din_i` valid this cycle.
- `din_r`, `din_i`  in  DATA_W  — signed input sample.
- `state`  in  2  — ROM phase: 0 fill, 1 butterfly, 2 twiddle; 3 illegal.
- `w_r`, `w_i`  in  DATA_W  — signed Q8 twiddle from the ROM, aligned with `state`.
- `out_valid`  out  1  — `dout_*` valid.
- `dout_r`, `dout_i`  out  DATA_W  — signed output sample.

## Operation
- Delay line: 128 × (2×DATA_W) circular buffer with one 7-bit pointer. Each advance cycle reads the head entry at `ptr`, writes the new entry at `ptr`, then increments `ptr` (wraps 127→0).
- Advance condition: `in_valid`=1, or `state`∈{1,2}. In state 1/2 with `in_valid`=0, din is treated as 0 (flush), matching the ROM's free-running phase counter.
- state 0 / state 3: write din to the delay line. No output is produced and `out_valid` is 0.
- state 1 (head a, input b):
  - output sat(a+b), computed at DATA_W+1 bits then saturated.
  - write sat(a−b) to the delay line.
- state 2 (head d):
  - output sat(round(d·w)):
    - re = (d_r·w_r − d_i·w_i + 2^(FRAC−1)) >>> FRAC
    - im = (d_r·w_i + d_i·w_r + 2^(FRAC−1)) >>> FRAC
    - products are 2·DATA_W bits, sums 2·DATA_W+1 bits, arithmetic shift, then saturate to DATA_W.
  - write din to the delay line; this is the next frame's first half.
- Saturation limits: +2^(DATA_W−1)−1 and −2^(DATA_W−1).
- Delay-line contents are not reset. The fill phase fully overwrites the buffer before any read.
- Twiddle (`w_r`, `w_i`) is sampled only in state 2. It is ignored otherwise.

## Timing
- All inputs, including the ROM's combinational `state`/`w_*`, are sampled on the same rising edge.
- Output latency is 1 cycle. `dout_*`/`out_valid` are registered and update on the edge after the sampling edge.
- Output order per frame, for input samples 0..255:
  - 128 sums X0[0..127], valid one cycle after samples 128..255.
  - 128 twiddled differences X1[0..127]·W^k, valid during the following 128 cycles.
- The twiddle for difference k is the ROM word at phase index 128+k.
- `out_valid`=1 exactly in the cycles following a sampled state 1 or 2.
- Reset values: `out_valid`=0, `dout_r`=0, `dout_i`=0, `ptr`=0.
- Reset mid-frame: the asynchronous clear takes effect immediately. The partial frame is discarded. The stage restarts at fill together with the ROM, which resets on the same `rst_n`.
- Back-to-back frames: state 2 cycles refill the buffer, so a continuous input stream needs no gap cycles. A sampled state 2→1 transition is seamless.
- state 3: treated as state 0 and produces no output. The stage has no error flag.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `out_valid`=0, `dout_*`=0. Deassert, send 128 samples in state 0 → `out_valid` stays 0.
- Impulse: x[0]=256+0j, all other samples 0 over 256 in_valid cycles → outputs:
  - first output (256,0), then 127 × (0,0);
  - then (256,0), since w=(256,0) gives (65536+128)>>8=256;
  - then 127 × (0,0).
  - `out_valid` high for 256 consecutive cycles, starting the cycle after sample 128.
- DC: all samples (100,−50) → 128 × (200,−100), then 128 × (0,0).
- Twiddle path: x[k]=(256,0) for k<128, x[k]=0 for k≥128 → difference k equals ROM twiddle k:
  - k=32 → (181,−181)
  - k=64 → (0,−256)
  - k=127 → (−256,−6)
- Saturation: x[0]=x[128]=(0x7FFFFF, 0x800000) → sum output (0x7FFFFF, 0x800000), saturated; difference 0 → (0,0).
- Reset mid-frame: assert `rst_n` at sample 200 of frame 1, then restart both ROM and stage with the DC frame → exact DC results. No residue from frame 1 appears.
